llsc_ctrl: RTL and testbench

//  MEM-stage LL/SC controller; direct upstream feeder of the LLbit register.

---
 rtl/llsc_ctrl_pkg.sv | 26 ++
 rtl/llsc_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_llsc_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/llsc_ctrl_pkg.sv
// ============================================================================
//  Module      : llsc_ctrl_pkg
//  Description : Shared opcodes, FSM state encoding and helpers for llsc_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package llsc_ctrl_pkg;

   localparam logic [7:0] EXE_LL_OP = 8'b11110000;
   localparam logic [7:0] EXE_SC_OP = 8'b11111000;

   typedef enum logic [1:0] {
      LLSC_IDLE    = 2'd0,
      LLSC_LL_WAIT = 2'd1,
      LLSC_SC_WAIT = 2'd2,
      LLSC_DRAIN   = 2'd3
   } llsc_state_t;

   function automatic logic is_llsc(input logic [7:0] op);
      return (op == EXE_LL_OP) || (op == EXE_SC_OP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/llsc_ctrl.sv
// ============================================================================
//  Module      : llsc_ctrl
//  Description : MEM-stage LL/SC controller: data-RAM handshake, link register,
//                SC success decision and LLbit write generation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module llsc_ctrl
   import llsc_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [7:0]        aluop_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic              LLbit_i,
   input  logic              wb_LLbit_we_i,
   input  logic              wb_LLbit_value_i,
   input  logic              snoop_we_i,
   input  logic [ADDR_W-1:0] snoop_addr_i,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [3:0]        mem_sel_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              wreg_o,
   output logic              LLbit_we_o,
   output logic              LLbit_value_o,
   output logic              misalign_o,
   output logic              stallreq_o
);

   localparam int WA_W = ADDR_W - 2;

   llsc_state_t       r_state, w_state_next;
   logic              r_link_valid, w_link_valid_next;
   logic [WA_W-1:0]   r_link_addr, w_link_addr_next;
   logic [WA_W-1:0]   r_acc_addr, w_acc_addr_next;
   logic [DATA_W-1:0] r_acc_data, w_acc_data_next;
   logic              r_acc_we, w_acc_we_next;

   logic              w_is_ll, w_is_sc, w_misalign;
   logic              w_eff_llbit, w_snoop_hit, w_sc_ok;
   logic [WA_W-1:0]   w_op_addr;
   logic              w_unused;

   assign w_unused    = ^snoop_addr_i[1:0];
   assign w_op_addr   = mem_addr_i[ADDR_W-1:2];
   assign w_is_ll     = (aluop_i == EXE_LL_OP);
   assign w_is_sc     = (aluop_i == EXE_SC_OP);
   assign w_misalign  = (w_is_ll | w_is_sc) & (mem_addr_i[1:0] != 2'b00);
   // A WB-stage LLbit write not yet visible in the register takes precedence.
   assign w_eff_llbit = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
   assign w_snoop_hit = snoop_we_i & (snoop_addr_i[ADDR_W-1:2] == r_link_addr);
   assign w_sc_ok     = w_eff_llbit & r_link_valid & (r_link_addr == w_op_addr) & ~w_snoop_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= LLSC_IDLE;
         r_link_valid <= 1'b0;
         r_link_addr  <= '0;
         r_acc_addr   <= '0;
         r_acc_data   <= '0;
         r_acc_we     <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_link_valid <= w_link_valid_next;
         r_link_addr  <= w_link_addr_next;
         r_acc_addr   <= w_acc_addr_next;
         r_acc_data   <= w_acc_data_next;
         r_acc_we     <= w_acc_we_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_link_valid_next = r_link_valid;
      w_link_addr_next  = r_link_addr;
      w_acc_addr_next   = r_acc_addr;
      w_acc_data_next   = r_acc_data;
      w_acc_we_next     = r_acc_we;
      mem_req_o         = 1'b0;
      mem_we_o          = 1'b0;
      mem_addr_o        = '0;
      mem_data_o        = '0;
      mem_sel_o         = 4'b0000;
      wdata_o           = '0;
      wreg_o            = 1'b0;
      LLbit_we_o        = 1'b0;
      LLbit_value_o     = 1'b0;
      misalign_o        = w_misalign;
      stallreq_o        = 1'b0;

      case (r_state)
         LLSC_IDLE: begin
            if (!flush && !w_misalign) begin
               if (w_is_ll) begin
                  mem_req_o       = 1'b1;
                  mem_addr_o      = {w_op_addr, 2'b00};
                  mem_sel_o       = 4'b1111;
                  stallreq_o      = 1'b1;
                  w_acc_addr_next = w_op_addr;
                  w_acc_we_next   = 1'b0;
                  w_state_next    = LLSC_LL_WAIT;
               end else if (w_is_sc) begin
                  if (w_sc_ok) begin
                     mem_req_o       = 1'b1;
                     mem_we_o        = 1'b1;
                     mem_addr_o      = {w_op_addr, 2'b00};
                     mem_data_o      = reg2_i;
                     mem_sel_o       = 4'b1111;
                     stallreq_o      = 1'b1;
                     w_acc_addr_next = w_op_addr;
                     w_acc_data_next = reg2_i;
                     w_acc_we_next   = 1'b1;
                     w_state_next    = LLSC_SC_WAIT;
                  end else begin
                     // Failed SC completes at once with a 0 result.
                     wreg_o = 1'b1;
                  end
               end
            end
         end

         LLSC_LL_WAIT: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {r_acc_addr, 2'b00};
            mem_sel_o  = 4'b1111;
            if (mem_ack_i) begin
               w_state_next = LLSC_IDLE;
               if (!flush) begin
                  wdata_o           = mem_data_i;
                  wreg_o            = 1'b1;
                  LLbit_we_o        = 1'b1;
                  LLbit_value_o     = 1'b1;
                  w_link_addr_next  = r_acc_addr;
                  w_link_valid_next = 1'b1;
               end
            end else if (flush) begin
               w_state_next = LLSC_DRAIN;
            end else begin
               stallreq_o = 1'b1;
            end
         end

         LLSC_SC_WAIT: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {r_acc_addr, 2'b00};
            mem_data_o = r_acc_data;
            mem_sel_o  = 4'b1111;
            if (mem_ack_i) begin
               w_state_next = LLSC_IDLE;
               if (!flush) begin
                  wdata_o           = {{(DATA_W-1){1'b0}}, 1'b1};
                  wreg_o            = 1'b1;
                  LLbit_we_o        = 1'b1;
                  w_link_valid_next = 1'b0;
               end
            end else if (flush) begin
               w_state_next = LLSC_DRAIN;
            end else begin
               stallreq_o = 1'b1;
            end
         end

         LLSC_DRAIN: begin
            // The abandoned access must still see its ack before the bus is free.
            mem_req_o  = 1'b1;
            mem_we_o   = r_acc_we;
            mem_addr_o = {r_acc_addr, 2'b00};
            mem_data_o = r_acc_we ? r_acc_data : '0;
            mem_sel_o  = 4'b1111;
            stallreq_o = !flush && is_llsc(aluop_i) && !w_misalign;
            if (mem_ack_i) begin
               w_state_next = LLSC_IDLE;
            end
         end

         default: begin
            w_state_next = LLSC_IDLE;
         end
      endcase

      if (w_snoop_hit || flush) begin
         w_link_valid_next = 1'b0;
      end

      if (rst) begin
         mem_req_o     = 1'b0;
         mem_we_o      = 1'b0;
         mem_addr_o    = '0;
         mem_data_o    = '0;
         mem_sel_o     = 4'b0000;
         wdata_o       = '0;
         wreg_o        = 1'b0;
         LLbit_we_o    = 1'b0;
         LLbit_value_o = 1'b0;
         misalign_o    = 1'b0;
         stallreq_o    = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_llsc_ctrl.sv
// Self-checking bench for llsc_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference model.
`default_nettype none

module tb_llsc_ctrl;
   import llsc_ctrl_pkg::*;

   logic        clk, rst, flush;
   logic [7:0]  aluop_i;
   logic [31:0] mem_addr_i, reg2_i, snoop_addr_i, mem_data_i;
   logic        LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i, snoop_we_i, mem_ack_i;
   logic        mem_req_o, mem_we_o, wreg_o, LLbit_we_o, LLbit_value_o, misalign_o, stallreq_o;
   logic [31:0] mem_addr_o, mem_data_o, wdata_o;
   logic [3:0]  mem_sel_o;
   logic [106:0] act_vec;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state (transaction level)
   bit          m_lv, m_busy, m_sc, m_drop;
   logic [29:0] m_la, m_aw;
   logic [31:0] m_wd;
   logic [106:0] e_vec;

   llsc_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
      .reg2_i(reg2_i), .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i),
      .wb_LLbit_value_i(wb_LLbit_value_i), .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o), .wdata_o(wdata_o),
      .wreg_o(wreg_o), .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o),
      .misalign_o(misalign_o), .stallreq_o(stallreq_o)
   );

   assign act_vec = {mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o, wdata_o,
                     wreg_o, LLbit_we_o, LLbit_value_o, misalign_o, stallreq_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit f_is_ll();  return aluop_i == EXE_LL_OP; endfunction
   function automatic bit f_is_sc();  return aluop_i == EXE_SC_OP; endfunction
   function automatic bit f_mis();    return (f_is_ll() || f_is_sc()) && (mem_addr_i[1:0] != 2'b00); endfunction
   function automatic bit f_hit();    return snoop_we_i && (snoop_addr_i[31:2] == m_la); endfunction
   function automatic bit f_ok();
      bit eff;
      eff = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
      return eff && m_lv && (m_la == mem_addr_i[31:2]) && !f_hit();
   endfunction

   // Model: outstanding access (if any), whether it was abandoned, and the link.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lv = 0; m_la = '0; m_busy = 0; m_sc = 0; m_drop = 0; m_aw = '0; m_wd = '0;
      end else begin
         bit hit, ok, nlv;
         hit = f_hit();
         ok  = f_ok();
         nlv = m_lv;
         if (m_busy) begin
            if (mem_ack_i) begin
               if (!m_drop && !flush) begin
                  if (m_sc) nlv = 0;
                  else begin m_la = m_aw; nlv = 1; end
               end
               m_busy = 0; m_drop = 0;
            end else if (flush) begin
               m_drop = 1;
            end
         end else if (!flush && !f_mis()) begin
            if (f_is_ll()) begin
               m_busy = 1; m_sc = 0; m_aw = mem_addr_i[31:2];
            end else if (f_is_sc() && ok) begin
               m_busy = 1; m_sc = 1; m_aw = mem_addr_i[31:2]; m_wd = reg2_i;
            end
         end
         if (hit || flush) nlv = 0;
         m_lv = nlv;
      end
   end

   task automatic model_outputs();
      logic        req, we, wreg, llwe, llv, stall, mis;
      logic [31:0] addr, md, wd;
      logic [3:0]  sel;
      req = 0; we = 0; wreg = 0; llwe = 0; llv = 0; stall = 0;
      addr = 0; md = 0; wd = 0; sel = 0;
      mis = f_mis();
      if (m_busy) begin
         req = 1; sel = 4'hF; we = m_sc; addr = {m_aw, 2'b00}; md = m_sc ? m_wd : 32'h0;
         if (flush) begin
         end else if (m_drop) begin
            stall = (f_is_ll() || f_is_sc()) && !mis;
         end else if (mem_ack_i) begin
            wreg = 1; llwe = 1; llv = !m_sc; wd = m_sc ? 32'h1 : mem_data_i;
         end else begin
            stall = 1;
         end
      end else if (!flush && !mis) begin
         if (f_is_ll()) begin
            req = 1; sel = 4'hF; addr = {mem_addr_i[31:2], 2'b00}; stall = 1;
         end else if (f_is_sc()) begin
            if (f_ok()) begin
               req = 1; we = 1; sel = 4'hF; addr = {mem_addr_i[31:2], 2'b00}; md = reg2_i; stall = 1;
            end else begin
               wreg = 1;
            end
         end
      end
      e_vec = {req, we, addr, md, sel, wd, wreg, llwe, llv, mis, stall};
   endtask

   task automatic idle_inputs();
      flush = 0; aluop_i = 8'h00; mem_addr_i = 0; reg2_i = 0; LLbit_i = 0;
      wb_LLbit_we_i = 0; wb_LLbit_value_i = 0; snoop_we_i = 0; snoop_addr_i = 0;
      mem_ack_i = 0; mem_data_i = 0;
   endtask

   task automatic run_ll(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); aluop_i = EXE_LL_OP; mem_addr_i = a; mem_ack_i = 0;
      @(negedge clk); mem_ack_i = 1; mem_data_i = d;
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      aluop_i = EXE_LL_OP; mem_addr_i = 32'h100;
      repeat (2) @(negedge clk);
      #2;
      n_tests++;
      if (act_vec !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", act_vec); end
      mem_addr_i = 32'h103; #1;
      n_tests++;
      if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
      @(negedge clk); rst = 0; aluop_i = EXE_SC_OP; mem_addr_i = 32'h0; LLbit_i = 1; #2;
      n_tests++;
      if ({mem_req_o, stallreq_o, wreg_o, wdata_o} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
         n_fail++; $display("FAIL reset_link_invalid: req=%b stall=%b wreg=%b wdata=%h want 0 0 1 0",
                            mem_req_o, stallreq_o, wreg_o, wdata_o);
      end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_ll_latency();
      int stalls; bit done;
      stalls = 0; done = 0;
      @(negedge clk); aluop_i = EXE_LL_OP; mem_addr_i = 32'h100;
      for (int i = 0; i < 10 && !done; i++) begin
         if (i > 0) @(negedge clk);
         mem_ack_i = (i == 3); mem_data_i = 32'hDEADBEEF;
         #2;
         if (i == 0) begin
            n_tests++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_sel_o} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
               n_fail++; $display("FAIL ll_request: req=%b we=%b addr=%h sel=%h want 1 0 100 f",
                                  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o);
            end
         end
         if (stallreq_o) stalls++;
         else begin
            done = 1;
            n_tests++;
            if ({wdata_o, wreg_o, LLbit_we_o, LLbit_value_o} !== {32'hDEADBEEF, 3'b111}) begin
               n_fail++; $display("FAIL ll_writeback: wdata=%h wreg=%b llwe=%b llv=%b want deadbeef 1 1 1",
                                  wdata_o, wreg_o, LLbit_we_o, LLbit_value_o);
            end
         end
      end
      n_tests++;
      if (stalls != 3 || !done) begin n_fail++; $display("FAIL ll_stall_cycles: got %0d want 3", stalls); end
      @(negedge clk); idle_inputs(); #2;
      n_tests++;
      if (act_vec !== '0) begin n_fail++; $display("FAIL nop_after_ll: got %h want 0", act_vec); end
   endtask

   task automatic test_ll_sc();
      run_ll(32'h100, 32'h12345678);
      aluop_i = EXE_SC_OP; mem_addr_i = 32'h100; reg2_i = 32'h55; LLbit_i = 1; #2;
      n_tests++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_data_o, stallreq_o} !== {2'b11, 32'h100, 32'h55, 1'b1}) begin
         n_fail++; $display("FAIL sc_request: req=%b we=%b addr=%h data=%h stall=%b want 1 1 100 55 1",
                            mem_req_o, mem_we_o, mem_addr_o, mem_data_o, stallreq_o);
      end
      @(negedge clk); mem_ack_i = 1; #2;
      n_tests++;
      if ({wdata_o, wreg_o, LLbit_we_o, LLbit_value_o, stallreq_o} !== {32'h1, 4'b1100}) begin
         n_fail++; $display("FAIL sc_success: wdata=%h wreg=%b llwe=%b llv=%b stall=%b want 1 1 1 0 0",
                            wdata_o, wreg_o, LLbit_we_o, LLbit_value_o, stallreq_o);
      end
      @(negedge clk); mem_ack_i = 0; #2;
      n_tests++;
      if ({mem_req_o, wreg_o, wdata_o} !== {2'b01, 32'h0}) begin
         n_fail++; $display("FAIL sc_after_sc: req=%b wreg=%b wdata=%h want 0 1 0", mem_req_o, wreg_o, wdata_o);
      end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_snoop();
      run_ll(32'h100, 32'h1);
      snoop_we_i = 1; snoop_addr_i = 32'h102;
      @(negedge clk); idle_inputs();
      aluop_i = EXE_SC_OP; mem_addr_i = 32'h100; reg2_i = 32'h77; LLbit_i = 1; #2;
      n_tests++;
      if ({mem_req_o, wreg_o, LLbit_we_o, stallreq_o, wdata_o} !== {4'b0100, 32'h0}) begin
         n_fail++; $display("FAIL snoop_kills_link: req=%b wreg=%b llwe=%b stall=%b wdata=%h want 0 1 0 0 0",
                            mem_req_o, wreg_o, LLbit_we_o, stallreq_o, wdata_o);
      end
      @(negedge clk); idle_inputs();
      run_ll(32'h100, 32'h2);
      snoop_we_i = 1; snoop_addr_i = 32'h104;
      @(negedge clk); idle_inputs();
      aluop_i = EXE_SC_OP; mem_addr_i = 32'h100; LLbit_i = 1; snoop_we_i = 1; snoop_addr_i = 32'h100; #2;
      n_tests++;
      if ({mem_req_o, wreg_o} !== 2'b01) begin
         n_fail++; $display("FAIL snoop_same_cycle: req=%b wreg=%b want 0 1", mem_req_o, wreg_o);
      end
      @(negedge clk); idle_inputs();
      run_ll(32'h100, 32'h3);
      snoop_we_i = 1; snoop_addr_i = 32'h104;
      @(negedge clk); idle_inputs();
      aluop_i = EXE_SC_OP; mem_addr_i = 32'h100; LLbit_i = 1; #2;
      n_tests++;
      if ({mem_req_o, stallreq_o} !== 2'b11) begin
         n_fail++; $display("FAIL snoop_other_word: req=%b stall=%b want 1 1", mem_req_o, stallreq_o);
      end
      @(negedge clk); mem_ack_i = 1;
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_bypass();
      run_ll(32'h100, 32'h4);
      aluop_i = EXE_SC_OP; mem_addr_i = 32'h100; LLbit_i = 1; wb_LLbit_we_i = 1; wb_LLbit_value_i = 0; #2;
      n_tests++;
      if ({mem_req_o, wreg_o, wdata_o} !== {2'b01, 32'h0}) begin
         n_fail++; $display("FAIL bypass_clear: req=%b wreg=%b wdata=%h want 0 1 0", mem_req_o, wreg_o, wdata_o);
      end
      @(negedge clk); LLbit_i = 0; wb_LLbit_we_i = 1; wb_LLbit_value_i = 1; #2;
      n_tests++;
      if ({mem_req_o, stallreq_o} !== 2'b11) begin
         n_fail++; $display("FAIL bypass_set: req=%b stall=%b want 1 1", mem_req_o, stallreq_o);
      end
      @(negedge clk); wb_LLbit_we_i = 0; mem_ack_i = 1;
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_flush_drain();
      @(negedge clk); aluop_i = EXE_LL_OP; mem_addr_i = 32'h200;
      @(negedge clk); flush = 1; #2;
      n_tests++;
      if ({mem_req_o, wreg_o, LLbit_we_o, stallreq_o} !== 4'b1000) begin
         n_fail++; $display("FAIL flush_cycle: req=%b wreg=%b llwe=%b stall=%b want 1 0 0 0",
                            mem_req_o, wreg_o, LLbit_we_o, stallreq_o);
      end
      @(negedge clk); flush = 0; mem_addr_i = 32'h300; #2;
      n_tests++;
      if ({mem_req_o, mem_addr_o, stallreq_o, wreg_o} !== {1'b1, 32'h200, 2'b10}) begin
         n_fail++; $display("FAIL drain_hold: req=%b addr=%h stall=%b wreg=%b want 1 200 1 0",
                            mem_req_o, mem_addr_o, stallreq_o, wreg_o);
      end
      @(negedge clk); mem_ack_i = 1; mem_data_i = 32'hAAAA; #2;
      n_tests++;
      if ({wreg_o, LLbit_we_o, stallreq_o} !== 3'b001) begin
         n_fail++; $display("FAIL drain_swallow: wreg=%b llwe=%b stall=%b want 0 0 1", wreg_o, LLbit_we_o, stallreq_o);
      end
      @(negedge clk); mem_ack_i = 0; #2;
      n_tests++;
      if ({mem_req_o, mem_addr_o, stallreq_o} !== {1'b1, 32'h300, 1'b1}) begin
         n_fail++; $display("FAIL post_drain_ll: req=%b addr=%h stall=%b want 1 300 1", mem_req_o, mem_addr_o, stallreq_o);
      end
      @(negedge clk); mem_ack_i = 1; mem_data_i = 32'hCAFE; #2;
      n_tests++;
      if ({wdata_o, wreg_o, stallreq_o} !== {32'hCAFE, 2'b10}) begin
         n_fail++; $display("FAIL post_drain_wb: wdata=%h wreg=%b stall=%b want cafe 1 0", wdata_o, wreg_o, stallreq_o);
      end
      @(negedge clk); idle_inputs();
      aluop_i = EXE_LL_OP; mem_addr_i = 32'h400;
      @(negedge clk); mem_ack_i = 1; flush = 1; #2;
      n_tests++;
      if ({wreg_o, LLbit_we_o} !== 2'b00) begin
         n_fail++; $display("FAIL ack_flush_wb: wreg=%b llwe=%b want 0 0", wreg_o, LLbit_we_o);
      end
      @(negedge clk); idle_inputs(); #2;
      n_tests++;
      if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL ack_flush_idle: req=%b want 0", mem_req_o); end
      aluop_i = EXE_SC_OP; mem_addr_i = 32'h300; LLbit_i = 1; #1;
      n_tests++;
      if ({mem_req_o, wreg_o} !== 2'b01) begin
         n_fail++; $display("FAIL flush_clears_link: req=%b wreg=%b want 0 1", mem_req_o, wreg_o);
      end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_misalign_rst();
      @(negedge clk); aluop_i = EXE_LL_OP; mem_addr_i = 32'h103; #2;
      n_tests++;
      if ({misalign_o, mem_req_o, stallreq_o, wreg_o, LLbit_we_o} !== 5'b10000) begin
         n_fail++; $display("FAIL ll_misalign: mis=%b req=%b stall=%b wreg=%b llwe=%b want 1 0 0 0 0",
                            misalign_o, mem_req_o, stallreq_o, wreg_o, LLbit_we_o);
      end
      @(negedge clk); aluop_i = EXE_SC_OP; mem_addr_i = 32'h101; LLbit_i = 1; #2;
      n_tests++;
      if ({misalign_o, mem_req_o, wreg_o} !== 3'b100) begin
         n_fail++; $display("FAIL sc_misalign: mis=%b req=%b wreg=%b want 1 0 0", misalign_o, mem_req_o, wreg_o);
      end
      @(negedge clk); idle_inputs();
      run_ll(32'h100, 32'h5);
      aluop_i = EXE_SC_OP; mem_addr_i = 32'h100; reg2_i = 32'h99; LLbit_i = 1;
      @(negedge clk); #2;
      n_tests++;
      if ({mem_req_o, mem_we_o, stallreq_o} !== 3'b111) begin
         n_fail++; $display("FAIL sc_wait: req=%b we=%b stall=%b want 1 1 1", mem_req_o, mem_we_o, stallreq_o);
      end
      rst = 1; #1;
      n_tests++;
      if (act_vec !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", act_vec); end
      @(negedge clk); rst = 0; #2;
      n_tests++;
      if ({mem_req_o, stallreq_o, wreg_o} !== 3'b001) begin
         n_fail++; $display("FAIL after_reset_sc: req=%b stall=%b wreg=%b want 0 0 1", mem_req_o, stallreq_o, wreg_o);
      end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_random();
      int delay, waitc; bit hold; int sel;
      logic [31:0] addrs [4];
      addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108; addrs[3] = 32'h10C;
      rst = 1; idle_inputs();
      @(negedge clk); rst = 0;
      hold = 0; delay = 1; waitc = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!hold) begin
            sel = $urandom_range(0, 9);
            aluop_i = (sel < 4) ? EXE_LL_OP : (sel < 8) ? EXE_SC_OP : 8'h21;
            mem_addr_i = addrs[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) mem_addr_i[1:0] = 2'($urandom_range(1, 3));
            reg2_i = $urandom;
         end
         flush            = ($urandom_range(0, 11) == 0);
         snoop_we_i       = ($urandom_range(0, 5) == 0);
         snoop_addr_i     = addrs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
         LLbit_i          = ($urandom_range(0, 7) != 0);
         wb_LLbit_we_i    = ($urandom_range(0, 7) == 0);
         wb_LLbit_value_i = 1'($urandom_range(0, 1));
         mem_ack_i        = m_busy && (waitc >= delay);
         mem_data_i       = $urandom;
         #2;
         model_outputs();
         n_tests++;
         if (act_vec !== e_vec) begin
            n_fail++; $display("FAIL random cycle %0d: got %h want %h", c, act_vec, e_vec);
         end
         hold = e_vec[0];
         if (mem_ack_i) begin waitc = 0; delay = $urandom_range(0, 2); end
         else if (m_busy) waitc++;
      end
      @(negedge clk); idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_ll_latency();
      test_ll_sc();
      test_snoop();
      test_bypass();
      test_flush_drain();
      test_misalign_rst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
